// File: rtl/ifq_pkg.sv
// Shared definitions for the instruction fetch queue: defaults, entry layout
// and pointer sizing.
package ifq_pkg;

    localparam int unsigned IFQ_DEPTH    = 8;
    localparam logic [31:0] IFQ_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_4;
    } ifq_entry_t;

    // Pointers carry one extra wrap bit above the slot index.
    function automatic int unsigned ifq_ptr_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ifq_storage.sv
// Entry storage for the fetch queue: one write port, one asynchronous read port.
// Data is not reset; the pointers in the parent decide which slots are valid.
module ifq_storage #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [63:0]   wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [63:0]   rd_data
);

    logic [63:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: sequential fetch from a one-cycle-latency imem into a
// show-ahead FIFO of {instruction, PC+4}, with flush-on-redirect from dispatch.
module ifetch_queue
    import ifq_pkg::*;
#(
    parameter int unsigned DEPTH    = IFQ_DEPTH,
    parameter logic [31:0] RESET_PC = IFQ_RESET_PC
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] ifetch_pc_4,
    output logic [31:0] ifetch_intruction,
    output logic        ifetch_empty,
    input  logic        Dispatch_ren,
    input  logic        Dispatch_jmp,
    input  logic [31:0] Dispatch_jmp_addr,
    output logic [31:0] ifq_imem_addr,
    output logic        ifq_imem_ren,
    input  logic [31:0] imem_data
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = ifq_ptr_w(DEPTH);

    logic [31:0]   fetch_pc;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          inflight;
    logic [31:0]   inflight_pc;
    logic          squash;

    logic [PW-1:0] count;
    logic [PW:0]   reserved;
    logic          issue;
    logic          resp;
    logic          pop;
    logic          wr_en;
    ifq_entry_t    wr_entry;
    ifq_entry_t    head;

    assign count    = wr_ptr - rd_ptr;
    assign reserved = {1'b0, count} + {{PW{1'b0}}, inflight};

    // Counting the in-flight request against capacity guarantees every
    // returning word finds a free slot.
    assign issue = !reset && !Dispatch_jmp && (reserved < (PW+1)'(DEPTH));
    assign resp  = inflight && !squash;
    assign pop   = Dispatch_ren && !ifetch_empty;
    assign wr_en = resp && !reset && !Dispatch_jmp;

    assign ifq_imem_ren  = issue;
    assign ifq_imem_addr = fetch_pc;

    assign wr_entry.instr = imem_data;
    assign wr_entry.pc_4  = inflight_pc + 32'd4;

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            squash      <= 1'b0;
            fetch_pc    <= RESET_PC;
        end else if (Dispatch_jmp) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            inflight <= 1'b0;
            squash   <= 1'b0;
            fetch_pc <= {Dispatch_jmp_addr[31:2], 2'b00};
        end else begin
            if (resp) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            inflight <= issue;
            if (issue) begin
                fetch_pc    <= fetch_pc + 32'd4;
                inflight_pc <= fetch_pc;
            end
        end
    end

    ifq_storage #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_storage (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (head)
    );

    assign ifetch_empty      = (count == '0);
    assign ifetch_intruction = ifetch_empty ? '0 : head.instr;
    assign ifetch_pc_4       = ifetch_empty ? '0 : head.pc_4;

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: a behavioural one-cycle imem returns ~addr,
// and each scenario task checks the queue outputs cycle by cycle.
module tb_ifetch_queue;

    logic        clock;
    logic        reset;
    logic [31:0] ifetch_pc_4;
    logic [31:0] ifetch_intruction;
    logic        ifetch_empty;
    logic        Dispatch_ren;
    logic        Dispatch_jmp;
    logic [31:0] Dispatch_jmp_addr;
    logic [31:0] ifq_imem_addr;
    logic        ifq_imem_ren;
    logic [31:0] imem_data;

    int total = 0;
    int bad   = 0;

    ifetch_queue #(
        .DEPTH    (8),
        .RESET_PC (32'h0000_0100)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .ifetch_pc_4       (ifetch_pc_4),
        .ifetch_intruction (ifetch_intruction),
        .ifetch_empty      (ifetch_empty),
        .Dispatch_ren      (Dispatch_ren),
        .Dispatch_jmp      (Dispatch_jmp),
        .Dispatch_jmp_addr (Dispatch_jmp_addr),
        .ifq_imem_addr     (ifq_imem_addr),
        .ifq_imem_ren      (ifq_imem_ren),
        .imem_data         (imem_data)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Instruction memory: word at address A reads back as ~A one cycle later.
    always @(posedge clock) begin
        imem_data <= ifq_imem_ren ? ~ifq_imem_addr : 32'hDEAD_BEEF;
    end

    // Set this cycle's inputs at the falling edge, then let outputs settle.
    task automatic cyc(input logic r, input logic pop, input logic jmp, input logic [31:0] ja);
        @(negedge clock);
        reset             = r;
        Dispatch_ren      = pop;
        Dispatch_jmp      = jmp;
        Dispatch_jmp_addr = ja;
        #1;
    endtask

    task automatic test_reset;
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        total++; if (ifetch_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%0b exp=1", ifetch_empty); end
        total++; if (ifetch_intruction !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h exp=0", ifetch_intruction); end
        total++; if (ifetch_pc_4 !== 32'h0) begin bad++; $display("FAIL reset_pc4 got=%h exp=0", ifetch_pc_4); end
        total++; if (ifq_imem_ren !== 1'b0) begin bad++; $display("FAIL reset_ren got=%0b exp=0", ifq_imem_ren); end
    endtask

    task automatic test_fill_and_full_pop;
        logic [31:0] exp_a;
        for (int c = 0; c < 10; c++) begin
            cyc(0, 0, 0, 0);
            exp_a = 32'h100 + 32'(4 * c);
            total++; if (ifq_imem_ren !== (c < 8)) begin bad++; $display("FAIL fill_ren c=%0d got=%0b exp=%0b", c, ifq_imem_ren, (c < 8)); end
            if (c < 8) begin
                total++; if (ifq_imem_addr !== exp_a) begin bad++; $display("FAIL fill_addr c=%0d got=%h exp=%h", c, ifq_imem_addr, exp_a); end
            end
            total++; if (ifetch_empty !== (c < 2)) begin bad++; $display("FAIL fill_empty c=%0d got=%0b exp=%0b", c, ifetch_empty, (c < 2)); end
            if (c >= 2) begin
                total++; if (ifetch_pc_4 !== 32'h104) begin bad++; $display("FAIL fill_pc4 c=%0d got=%h exp=104", c, ifetch_pc_4); end
                total++; if (ifetch_intruction !== ~32'h100) begin bad++; $display("FAIL fill_instr c=%0d got=%h exp=%h", c, ifetch_intruction, ~32'h100); end
            end
        end
        // Full: one pop frees exactly one slot, reissued the next cycle.
        cyc(0, 1, 0, 0);
        total++; if (ifq_imem_ren !== 1'b0) begin bad++; $display("FAIL full_ren got=%0b exp=0", ifq_imem_ren); end
        total++; if (ifetch_pc_4 !== 32'h104) begin bad++; $display("FAIL full_head got=%h exp=104", ifetch_pc_4); end
        cyc(0, 0, 0, 0);
        total++; if (ifq_imem_ren !== 1'b1) begin bad++; $display("FAIL refill_ren got=%0b exp=1", ifq_imem_ren); end
        total++; if (ifq_imem_addr !== 32'h120) begin bad++; $display("FAIL refill_addr got=%h exp=120", ifq_imem_addr); end
        total++; if (ifetch_pc_4 !== 32'h108) begin bad++; $display("FAIL refill_head got=%h exp=108", ifetch_pc_4); end
        cyc(0, 0, 0, 0);
        total++; if (ifq_imem_ren !== 1'b0) begin bad++; $display("FAIL refill_stop1 got=%0b exp=0", ifq_imem_ren); end
        cyc(0, 0, 0, 0);
        total++; if (ifq_imem_ren !== 1'b0) begin bad++; $display("FAIL refill_stop2 got=%0b exp=0", ifq_imem_ren); end
        // Drain from full while fetching resumes: no entry lost, no bubble.
        for (int k = 0; k < 12; k++) begin
            cyc(0, 1, 0, 0);
            exp_a = 32'h108 + 32'(4 * k);
            total++; if (ifetch_empty !== 1'b0) begin bad++; $display("FAIL drain_empty k=%0d got=%0b exp=0", k, ifetch_empty); end
            total++; if (ifetch_pc_4 !== exp_a) begin bad++; $display("FAIL drain_pc4 k=%0d got=%h exp=%h", k, ifetch_pc_4, exp_a); end
            total++; if (ifetch_intruction !== ~(exp_a - 32'd4)) begin bad++; $display("FAIL drain_instr k=%0d got=%h exp=%h", k, ifetch_intruction, ~(exp_a - 32'd4)); end
        end
    endtask

    task automatic test_streaming;
        logic [31:0] exp_p;
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        for (int c = 0; c < 16; c++) begin
            cyc(0, 1, 0, 0);
            total++; if (ifq_imem_ren !== 1'b1 || ifq_imem_addr !== 32'h100 + 32'(4 * c)) begin bad++; $display("FAIL stream_req c=%0d got=%0b/%h exp=1/%h", c, ifq_imem_ren, ifq_imem_addr, 32'h100 + 32'(4 * c)); end
            total++; if (ifetch_empty !== (c < 2)) begin bad++; $display("FAIL stream_empty c=%0d got=%0b exp=%0b", c, ifetch_empty, (c < 2)); end
            if (c >= 2) begin
                exp_p = 32'h104 + 32'(4 * (c - 2));
                total++; if (ifetch_pc_4 !== exp_p) begin bad++; $display("FAIL stream_pc4 c=%0d got=%h exp=%h", c, ifetch_pc_4, exp_p); end
            end
        end
    endtask

    task automatic test_redirect;
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        for (int c = 0; c < 4; c++) cyc(0, 0, 0, 0);
        cyc(0, 1, 1, 32'h400);
        total++; if (ifq_imem_ren !== 1'b0) begin bad++; $display("FAIL jmp_ren got=%0b exp=0", ifq_imem_ren); end
        total++; if (ifetch_empty !== 1'b0 || ifetch_pc_4 !== 32'h104) begin bad++; $display("FAIL jmp_pre_head got=%0b/%h exp=0/104", ifetch_empty, ifetch_pc_4); end
        cyc(0, 0, 0, 0);
        total++; if (ifetch_empty !== 1'b1) begin bad++; $display("FAIL jmp_flush got=%0b exp=1", ifetch_empty); end
        total++; if (ifq_imem_ren !== 1'b1 || ifq_imem_addr !== 32'h400) begin bad++; $display("FAIL jmp_target got=%0b/%h exp=1/400", ifq_imem_ren, ifq_imem_addr); end
        cyc(0, 0, 0, 0);
        total++; if (ifetch_empty !== 1'b1 || ifq_imem_addr !== 32'h404) begin bad++; $display("FAIL jmp_j2 got=%0b/%h exp=1/404", ifetch_empty, ifq_imem_addr); end
        cyc(0, 0, 0, 0);
        total++; if (ifetch_empty !== 1'b0 || ifetch_pc_4 !== 32'h404) begin bad++; $display("FAIL jmp_head got=%0b/%h exp=0/404", ifetch_empty, ifetch_pc_4); end
        total++; if (ifetch_intruction !== ~32'h400) begin bad++; $display("FAIL jmp_instr got=%h exp=%h", ifetch_intruction, ~32'h400); end
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        total++; if (ifetch_pc_4 !== 32'h408) begin bad++; $display("FAIL jmp_next got=%h exp=408", ifetch_pc_4); end
        // Back-to-back jumps: the second (misaligned) target wins.
        cyc(0, 0, 1, 32'h200);
        total++; if (ifq_imem_ren !== 1'b0) begin bad++; $display("FAIL b2b_ren1 got=%0b exp=0", ifq_imem_ren); end
        cyc(0, 0, 1, 32'h50A);
        total++; if (ifq_imem_ren !== 1'b0 || ifetch_empty !== 1'b1) begin bad++; $display("FAIL b2b_ren2 got=%0b/%0b exp=0/1", ifq_imem_ren, ifetch_empty); end
        cyc(0, 0, 0, 0);
        total++; if (ifetch_empty !== 1'b1 || ifq_imem_addr !== 32'h508) begin bad++; $display("FAIL b2b_addr got=%0b/%h exp=1/508", ifetch_empty, ifq_imem_addr); end
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        total++; if (ifetch_empty !== 1'b0 || ifetch_pc_4 !== 32'h50C) begin bad++; $display("FAIL b2b_head got=%0b/%h exp=0/50c", ifetch_empty, ifetch_pc_4); end
        total++; if (ifetch_intruction !== ~32'h508) begin bad++; $display("FAIL b2b_instr got=%h exp=%h", ifetch_intruction, ~32'h508); end
    endtask

    task automatic test_pop_empty_wrap;
        cyc(0, 0, 1, 32'hFFFF_FFFC);
        total++; if (ifq_imem_ren !== 1'b0) begin bad++; $display("FAIL wrap_jmp_ren got=%0b exp=0", ifq_imem_ren); end
        cyc(0, 1, 0, 0);
        total++; if (ifetch_empty !== 1'b1 || ifq_imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_top got=%0b/%h exp=1/fffffffc", ifetch_empty, ifq_imem_addr); end
        cyc(0, 1, 0, 0);
        total++; if (ifetch_empty !== 1'b1 || ifq_imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_zero got=%0b/%h exp=1/0", ifetch_empty, ifq_imem_addr); end
        cyc(0, 0, 0, 0);
        total++; if (ifetch_empty !== 1'b0 || ifetch_pc_4 !== 32'h0) begin bad++; $display("FAIL wrap_head got=%0b/%h exp=0/0", ifetch_empty, ifetch_pc_4); end
        total++; if (ifetch_intruction !== 32'h3) begin bad++; $display("FAIL wrap_instr got=%h exp=3", ifetch_intruction); end
        cyc(0, 1, 0, 0);
        total++; if (ifetch_pc_4 !== 32'h0) begin bad++; $display("FAIL empty_pop_held got=%h exp=0", ifetch_pc_4); end
        cyc(0, 0, 0, 0);
        total++; if (ifetch_pc_4 !== 32'h4 || ifetch_intruction !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_next got=%h/%h exp=4/ffffffff", ifetch_pc_4, ifetch_intruction); end
    endtask

    task automatic test_reset_midstream;
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        for (int c = 0; c < 4; c++) cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        total++; if (ifq_imem_ren !== 1'b0) begin bad++; $display("FAIL mrst_ren0 got=%0b exp=0", ifq_imem_ren); end
        cyc(1, 0, 0, 0);
        total++; if (ifetch_empty !== 1'b1 || ifq_imem_ren !== 1'b0) begin bad++; $display("FAIL mrst_state got=%0b/%0b exp=1/0", ifetch_empty, ifq_imem_ren); end
        total++; if (ifetch_pc_4 !== 32'h0 || ifetch_intruction !== 32'h0) begin bad++; $display("FAIL mrst_head got=%h/%h exp=0/0", ifetch_pc_4, ifetch_intruction); end
        cyc(0, 0, 0, 0);
        total++; if (ifetch_empty !== 1'b1 || ifq_imem_addr !== 32'h100 || ifq_imem_ren !== 1'b1) begin bad++; $display("FAIL mrst_restart got=%0b/%h/%0b exp=1/100/1", ifetch_empty, ifq_imem_addr, ifq_imem_ren); end
        cyc(0, 0, 0, 0);
        total++; if (ifetch_empty !== 1'b1) begin bad++; $display("FAIL mrst_stale got=%0b exp=1", ifetch_empty); end
        cyc(0, 0, 0, 0);
        total++; if (ifetch_empty !== 1'b0 || ifetch_pc_4 !== 32'h104) begin bad++; $display("FAIL mrst_first got=%0b/%h exp=0/104", ifetch_empty, ifetch_pc_4); end
    endtask

    initial begin
        reset             = 1'b1;
        Dispatch_ren      = 1'b0;
        Dispatch_jmp      = 1'b0;
        Dispatch_jmp_addr = '0;
        test_reset;
        test_fill_and_full_pop;
        test_streaming;
        test_redirect;
        test_pop_empty_wrap;
        test_reset_midstream;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Instruction fetch queue (IFQ) feeding `dispatch_unit`. Fetches sequential instructions from a one-cycle-latency instruction memory, buffers them with their PC+4 in a show-ahead FIFO, and presents the head entry to dispatch. Dispatch pops the head with `Dispatch_ren`. Dispatch redirects the queue with `Dispatch_jmp`/`Dispatch_jmp_addr`, which flushes all buffered and in-flight instructions.

## Interface
- `DEPTH`, default 8: FIFO entries; must be a power of 2, ≥ 2.
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.

Ports:
- `clock`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `ifetch_pc_4`, out, 32: PC+4 of the head instruction; 0 when empty.
- `ifetch_intruction`, out, 32: head instruction; 0 when empty.
- `ifetch_empty`, out, 1: 1 means the head is invalid.
- `Dispatch_ren`, in, 1: pop the head entry; ignored when empty.
- `Dispatch_jmp`, in, 1: redirect and flush.
- `Dispatch_jmp_addr`, in, 32: redirect target, sampled when `Dispatch_jmp` = 1.
- `ifq_imem_addr`, out, 32: instruction memory read address (word aligned).
- `ifq_imem_ren`, out, 1: read request. Data is returned exactly one cycle later.
- `imem_data`, in, 32: read data, valid in the cycle after `ifq_imem_ren`.

## Operation
- **State**
  - `fetch_pc` (32 bits).
  - `rd_ptr` and `wr_ptr`, each log2(DEPTH)+1 bits, with the MSB as the wrap bit.
  - `inflight` (1 bit): a request was issued last cycle.
  - `inflight_pc` (32 bits).
  - `squash` (1 bit).
- **Occupancy**
  - `count = wr_ptr - rd_ptr`.
  - Full: MSBs differ and the low bits are equal.
  - Empty: `count == 0`.
- **Issue rule**
  - Issue when `reset` = 0, `Dispatch_jmp` = 0, and `count + inflight < DEPTH`.
  - Issuing asserts `ifq_imem_ren`, drives `ifq_imem_addr = fetch_pc`, then sets `fetch_pc += 4`, `inflight` = 1 and `inflight_pc = fetch_pc`.
  - The reservation guarantees a returning word always has a free slot.
- **Response**
  - When `inflight` = 1 and `squash` = 0, write `{imem_data, inflight_pc + 4}` at `wr_ptr[low]`, then increment `wr_ptr`.
- **Pop**
  - When `Dispatch_ren` = 1 and the queue is not empty, increment `rd_ptr`.
  - A pop and a response in the same cycle are both honoured; `count` is unchanged.
- **Redirect** (`Dispatch_jmp` = 1) has priority over everything:
  - `rd_ptr` and `wr_ptr` are set to 0; the queue is empty next cycle.
  - `fetch_pc` is set to `Dispatch_jmp_addr`.
  - No request is issued this cycle.
  - A response arriving this cycle is discarded.
  - `Dispatch_ren` is ignored this cycle.
  - `squash` is set to 0; no request was issued, so next cycle has nothing in flight.
  - A response pending from a request made in the jump cycle cannot exist, because issue is blocked in that cycle.
  - Back-to-back jumps: the last one wins, and each jump flushes again.
- **Pop while empty**: no effect; `rd_ptr` must never pass `wr_ptr`.
- **PC arithmetic**: modulo 2^32, so 32'hFFFF_FFFC wraps to 0. The low 2 bits of `Dispatch_jmp_addr` are forced to 0.

## Timing
- **Reset** (synchronous): when sampled high, the following take effect at the next edge.
  - `rd_ptr` = `wr_ptr` = 0, `inflight` = 0, `squash` = 0, `fetch_pc` = `RESET_PC`.
  - `ifetch_empty` = 1, `ifetch_intruction` = 0, `ifetch_pc_4` = 0, `ifq_imem_ren` = 0.
  - A reset mid-stream discards everything, including an in-flight response.
- **Fetch latency**
  - Request issued in cycle N, data captured at the end of N+1, `ifetch_empty` = 0 in N+2.
  - First instruction is visible in cycle 2 after reset release.
- **Redirect latency**
  - `Dispatch_jmp` in cycle J gives empty in J+1, the target request in J+1, and the target instruction visible in J+3.
- **Head outputs**: combinational from the storage read at `rd_ptr` and gated by empty. There is no write-through into an empty queue.
- **Steady state**: one instruction per cycle when dispatch pops every cycle.

## Structure
- **Package `ifq_pkg`**
  - `IFQ_DEPTH` and `IFQ_RESET_PC` defaults.
  - Typedef `ifq_entry_t {logic [31:0] instr; logic [31:0] pc_4;}`.
  - Pointer width function.
- **Sub-module `ifq_storage`**
  - DEPTH × 64-bit register array.
  - One write port and one asynchronous read port.
  - No reset on the data; validity comes from the pointers.
- Top level holds the pointers, the fetch PC, in-flight tracking and output gating.

## Test plan
- **Reset fill**: release reset with `RESET_PC` = 0x100 and no pops. Requests go to 0x100..0x11C. `ifetch_empty` falls in cycle 2 with `ifetch_pc_4` = 0x104. `ifq_imem_ren` stops once `count + inflight` = 8.
- **Streaming**: pop every cycle from cycle 2. The `ifetch_pc_4` sequence is 0x104, 0x108, 0x10C, … with no bubbles, and `count` stays at 1.
- **Full with simultaneous pop**: fill to 8, then pop once. Exactly one new request issues the next cycle, with no overflow and no lost entry.
- **Redirect with in-flight data**: with 3 entries and a request in flight, assert `Dispatch_jmp` with address 0x400 and `Dispatch_ren` = 1. Empty next cycle, the in-flight word is discarded, and the head shows `ifetch_pc_4` = 0x404 two cycles later.
- **Pop while empty plus PC wrap**: pulse `Dispatch_ren` while empty; the pointers are unchanged. Jump to 0xFFFFFFFC; the next fetch address is 0x0 and the head's `ifetch_pc_4` = 0x0.
- **Reset mid-stream**: assert `reset` with a request in flight. Next cycle empty = 1 and `ren` = 0, and no stale entry appears after release.
